// File: rtl/verificador_de_senha_parametrizavel.sv
// rtl/verificador_de_senha_parametrizavel.sv - password checker with lockout and reprogramming
// Optional inter-code idle timeout: define TIMEOUT_ENTRE_CODIGOS_EN.
module verificador_de_senha_parametrizavel #(
  parameter int LARGURA_CODIGO  = 4,
  parameter int NUM_CODIGOS     = 4,
  parameter int MAX_TENTATIVAS  = 3,
  parameter int CICLOS_BLOQUEIO = 16,
  parameter logic [LARGURA_CODIGO*NUM_CODIGOS-1:0] SENHA_PADRAO =
    {4'b1000, 4'b0100, 4'b0010, 4'b0001},
  parameter int TEMPO_LIMITE    = 64,
  localparam int IW = (NUM_CODIGOS > 1) ? $clog2(NUM_CODIGOS) : 1,
  localparam int TW = $clog2(MAX_TENTATIVAS + 1)
) (
  input  logic                                   CLK,
  input  logic                                   ON_OFF,
  input  logic [LARGURA_CODIGO-1:0]              CODIGO_INSERIDO,
  input  logic                                   CODIGO_VALIDO,
  input  logic                                   LIMPAR,
  input  logic                                   GRAVAR_SENHA,
  input  logic [LARGURA_CODIGO*NUM_CODIGOS-1:0]  NOVA_SENHA,
  output logic                                   ERRO,
  output logic                                   SENHA_CERTA,
  output logic                                   BLOQUEADO,
  output logic [IW-1:0]                          INDICE,
  output logic [TW-1:0]                          TENTATIVAS
);

  localparam int PW = LARGURA_CODIGO * NUM_CODIGOS;
  localparam int CW = $clog2(CICLOS_BLOQUEIO + 1);

  typedef enum logic [1:0] {S_COLETA, S_ERRO, S_BLOQUEIO, S_CERTO} estado_t;

  estado_t             estado, estado_n;
  logic [PW-1:0]       senha, senha_n;
  logic                divergencia, divergencia_n;
  logic [CW-1:0]       contador, contador_n;
  logic [IW-1:0]       indice_n;
  logic [TW-1:0]       tentativas_n, tentativas_inc;
  logic                erro_n, certa_n, bloqueado_n;
  logic                falha;
  logic                diverge_atual;

`ifdef TIMEOUT_ENTRE_CODIGOS_EN
  localparam int OW = $clog2(TEMPO_LIMITE + 1);
  logic [OW-1:0]       ocioso, ocioso_n;
`endif

  assign diverge_atual  = (CODIGO_INSERIDO != senha[INDICE*LARGURA_CODIGO +: LARGURA_CODIGO]);
  assign tentativas_inc = TENTATIVAS + 1'b1;

  always_comb begin
    estado_n      = estado;
    senha_n       = senha;
    divergencia_n = divergencia;
    contador_n    = contador;
    indice_n      = INDICE;
    tentativas_n  = TENTATIVAS;
    erro_n        = ERRO;
    certa_n       = SENHA_CERTA;
    bloqueado_n   = BLOQUEADO;
    falha         = 1'b0;
`ifdef TIMEOUT_ENTRE_CODIGOS_EN
    ocioso_n      = '0;
`endif

    case (estado)
      S_COLETA: begin
        if (LIMPAR) begin
          indice_n      = '0;
          divergencia_n = 1'b0;
        end else if (CODIGO_VALIDO) begin
          // every code is collected before the verdict so the failing position never leaks
          if (INDICE == IW'(NUM_CODIGOS - 1)) begin
            indice_n      = '0;
            divergencia_n = 1'b0;
            if (divergencia || diverge_atual) begin
              falha = 1'b1;
            end else begin
              estado_n     = S_CERTO;
              certa_n      = 1'b1;
              tentativas_n = '0;
            end
          end else begin
            indice_n      = INDICE + 1'b1;
            divergencia_n = divergencia | diverge_atual;
          end
        end
`ifdef TIMEOUT_ENTRE_CODIGOS_EN
        else if (INDICE != '0) begin
          if (ocioso == OW'(TEMPO_LIMITE - 1)) begin
            indice_n      = '0;
            divergencia_n = 1'b0;
            falha         = 1'b1;
          end else begin
            ocioso_n = ocioso + 1'b1;
          end
        end
`endif
      end

      S_ERRO: begin
        if (LIMPAR) begin
          erro_n   = 1'b0;
          estado_n = S_COLETA;
        end else if (CODIGO_VALIDO) begin
          // INDICE is 0 here, so this code is checked as the first of a new attempt
          erro_n        = 1'b0;
          estado_n      = S_COLETA;
          indice_n      = IW'(1);
          divergencia_n = diverge_atual;
        end
      end

      S_BLOQUEIO: begin
        if (contador == CW'(1)) begin
          contador_n   = '0;
          bloqueado_n  = 1'b0;
          tentativas_n = '0;
          estado_n     = S_COLETA;
        end else begin
          contador_n = contador - 1'b1;
        end
      end

      S_CERTO: begin
        if (GRAVAR_SENHA) begin
          senha_n  = NOVA_SENHA;
          certa_n  = 1'b0;
          estado_n = S_COLETA;
        end else if (LIMPAR) begin
          certa_n  = 1'b0;
          estado_n = S_COLETA;
        end
      end

      default: estado_n = S_COLETA;
    endcase

    if (falha) begin
      tentativas_n = tentativas_inc;
      if (tentativas_inc == TW'(MAX_TENTATIVAS)) begin
        estado_n    = S_BLOQUEIO;
        bloqueado_n = 1'b1;
        contador_n  = CW'(CICLOS_BLOQUEIO);
      end else begin
        estado_n = S_ERRO;
        erro_n   = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge ON_OFF) begin
    if (!ON_OFF) begin
      estado      <= S_COLETA;
      senha       <= SENHA_PADRAO;
      divergencia <= 1'b0;
      contador    <= '0;
      INDICE      <= '0;
      TENTATIVAS  <= '0;
      ERRO        <= 1'b0;
      SENHA_CERTA <= 1'b0;
      BLOQUEADO   <= 1'b0;
    end else begin
      estado      <= estado_n;
      senha       <= senha_n;
      divergencia <= divergencia_n;
      contador    <= contador_n;
      INDICE      <= indice_n;
      TENTATIVAS  <= tentativas_n;
      ERRO        <= erro_n;
      SENHA_CERTA <= certa_n;
      BLOQUEADO   <= bloqueado_n;
    end
  end

`ifdef TIMEOUT_ENTRE_CODIGOS_EN
  always_ff @(posedge CLK or negedge ON_OFF) begin
    if (!ON_OFF) ocioso <= '0;
    else         ocioso <= ocioso_n;
  end
`endif

endmodule

// File: tb/tb_verificador_de_senha_parametrizavel.sv
// tb/tb_verificador_de_senha_parametrizavel.sv - scoreboard bench for the password checker
module tb_verificador_de_senha_parametrizavel;

  logic        CLK = 1'b0;
  logic        ON_OFF;
  logic [3:0]  CODIGO_INSERIDO;
  logic        CODIGO_VALIDO;
  logic        LIMPAR;
  logic        GRAVAR_SENHA;
  logic [15:0] NOVA_SENHA;
  logic        ERRO;
  logic        SENHA_CERTA;
  logic        BLOQUEADO;
  logic [1:0]  INDICE;
  logic [1:0]  TENTATIVAS;

  int n_vetores = 0;
  int n_erros   = 0;

  typedef struct packed {
    logic       erro;
    logic       certa;
    logic       bloq;
    logic [1:0] ind;
    logic [1:0] tent;
  } esperado_t;

  esperado_t fila[$];

  verificador_de_senha_parametrizavel dut (
    .CLK             (CLK),
    .ON_OFF          (ON_OFF),
    .CODIGO_INSERIDO (CODIGO_INSERIDO),
    .CODIGO_VALIDO   (CODIGO_VALIDO),
    .LIMPAR          (LIMPAR),
    .GRAVAR_SENHA    (GRAVAR_SENHA),
    .NOVA_SENHA      (NOVA_SENHA),
    .ERRO            (ERRO),
    .SENHA_CERTA     (SENHA_CERTA),
    .BLOQUEADO       (BLOQUEADO),
    .INDICE          (INDICE),
    .TENTATIVAS      (TENTATIVAS)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vetores++;
    if (obs !== exp) begin
      n_erros++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic esperado_t ex(input logic er, input logic ce, input logic bl,
                                   input int ind, input int tent);
    esperado_t r;
    r.erro  = er;
    r.certa = ce;
    r.bloq  = bl;
    r.ind   = 2'(ind);
    r.tent  = 2'(tent);
    return r;
  endfunction

  task automatic check_saidas(input string tag, input esperado_t e);
    check({tag, ".erro"},  ERRO,        e.erro);
    check({tag, ".certa"}, SENHA_CERTA, e.certa);
    check({tag, ".bloq"},  BLOQUEADO,   e.bloq);
    check({tag, ".ind"},   INDICE,      e.ind);
    check({tag, ".tent"},  TENTATIVAS,  e.tent);
  endtask

  task automatic step(input string tag, input logic v, input logic [3:0] c, input logic l,
                      input logic g, input logic [15:0] n, input esperado_t e);
    esperado_t alvo;
    CODIGO_VALIDO   = v;
    CODIGO_INSERIDO = c;
    LIMPAR          = l;
    GRAVAR_SENHA    = g;
    NOVA_SENHA      = n;
    fila.push_back(e);
    @(posedge CLK);
    #1;
    alvo = fila.pop_front();
    check_saidas(tag, alvo);
    CODIGO_VALIDO = 1'b0;
    LIMPAR        = 1'b0;
    GRAVAR_SENHA  = 1'b0;
  endtask

  task automatic codigo(input string tag, input logic [3:0] c, input esperado_t e);
    step(tag, 1'b1, c, 1'b0, 1'b0, 16'h0, e);
  endtask

  task automatic ocioso(input string tag, input esperado_t e);
    step(tag, 1'b0, 4'h0, 1'b0, 1'b0, 16'h0, e);
  endtask

  task automatic limpar(input string tag, input esperado_t e);
    step(tag, 1'b0, 4'h0, 1'b1, 1'b0, 16'h0, e);
  endtask

  // code k of a full entry sits at bits [4k +: 4], same packing as the password
  task automatic entrada(input string tag, input logic [15:0] s, input int tent, input esperado_t fim);
    for (int k = 0; k < 3; k++) codigo(tag, s[k*4 +: 4], ex(0, 0, 0, k + 1, tent));
    codigo(tag, s[15:12], fim);
  endtask

  task automatic reset_assincrono(input string tag);
    ON_OFF = 1'b0;
    #2;
    check_saidas(tag, ex(0, 0, 0, 0, 0));
    ON_OFF = 1'b1;
  endtask

  initial begin
    ON_OFF = 1'b0;
    CODIGO_INSERIDO = '0;
    CODIGO_VALIDO = 1'b0;
    LIMPAR = 1'b0;
    GRAVAR_SENHA = 1'b0;
    NOVA_SENHA = '0;
    repeat (2) @(posedge CLK);
    #1;
    check_saidas("reset", ex(0, 0, 0, 0, 0));
    @(negedge CLK);
    ON_OFF = 1'b1;

    entrada("certa", 16'h8421, 0, ex(0, 1, 0, 0, 0));
    codigo("certo_ignora", 4'h1, ex(0, 1, 0, 0, 0));
    limpar("sai_certo", ex(0, 0, 0, 0, 0));

    entrada("errada", 16'h8431, 0, ex(1, 0, 0, 0, 1));
    ocioso("erro_mantem", ex(1, 0, 0, 0, 1));
    codigo("erro_cod0", 4'h1, ex(0, 0, 0, 1, 1));
    codigo("erro_cod1", 4'h2, ex(0, 0, 0, 2, 1));
    codigo("erro_cod2", 4'h4, ex(0, 0, 0, 3, 1));
    codigo("erro_cod3", 4'h8, ex(0, 1, 0, 0, 0));
    limpar("sai_certo2", ex(0, 0, 0, 0, 0));

    entrada("t1", 16'h0000, 0, ex(1, 0, 0, 0, 1));
    entrada("t2", 16'h0000, 1, ex(1, 0, 0, 0, 2));
    limpar("limpa_erro", ex(0, 0, 0, 0, 2));
    step("gravar_fora", 1'b0, 4'h0, 1'b0, 1'b1, 16'h0000, ex(0, 0, 0, 0, 2));
    entrada("t3", 16'h0000, 2, ex(0, 0, 1, 0, 3));
    for (int i = 1; i < 16; i++)
      step("bloqueio", 1'b1, 4'h1, 1'(i & 1), 1'(i >> 1), 16'h0000, ex(0, 0, 1, 0, 3));
    ocioso("fim_bloqueio", ex(0, 0, 0, 0, 0));
    entrada("pos_bloqueio", 16'h8421, 0, ex(0, 1, 0, 0, 0));

    step("gravar", 1'b0, 4'h0, 1'b1, 1'b1, 16'h5A3C, ex(0, 0, 0, 0, 0));
    entrada("nova", 16'h5A3C, 0, ex(0, 1, 0, 0, 0));
    limpar("sai_certo3", ex(0, 0, 0, 0, 0));
    entrada("antiga", 16'h8421, 0, ex(1, 0, 0, 0, 1));
    limpar("limpa_erro2", ex(0, 0, 0, 0, 1));
    codigo("parcial0", 4'hC, ex(0, 0, 0, 1, 1));
    codigo("parcial1", 4'h3, ex(0, 0, 0, 2, 1));
    limpar("descarta", ex(0, 0, 0, 0, 1));
    step("limpar_vence", 1'b1, 4'hC, 1'b1, 1'b0, 16'h0000, ex(0, 0, 0, 0, 1));
    entrada("nova2", 16'h5A3C, 1, ex(0, 1, 0, 0, 0));

    limpar("sai_certo4", ex(0, 0, 0, 0, 0));
    codigo("meio0", 4'hC, ex(0, 0, 0, 1, 0));
    codigo("meio1", 4'h3, ex(0, 0, 0, 2, 0));
    reset_assincrono("reset_meio");
    entrada("padrao", 16'h8421, 0, ex(0, 1, 0, 0, 0));

    step("gravar2", 1'b0, 4'h0, 1'b0, 1'b1, 16'h5A3C, ex(0, 0, 0, 0, 0));
    entrada("b1", 16'h0000, 0, ex(1, 0, 0, 0, 1));
    entrada("b2", 16'h0000, 1, ex(1, 0, 0, 0, 2));
    entrada("b3", 16'h0000, 2, ex(0, 0, 1, 0, 3));
    ocioso("bloq_ativo", ex(0, 0, 1, 0, 3));
    reset_assincrono("reset_bloq");
    entrada("padrao2", 16'h8421, 0, ex(0, 1, 0, 0, 0));

`ifdef TIMEOUT_ENTRE_CODIGOS_EN
    limpar("sai_certo5", ex(0, 0, 0, 0, 0));
    codigo("to0", 4'h1, ex(0, 0, 0, 1, 0));
    codigo("to1", 4'h2, ex(0, 0, 0, 2, 0));
    for (int i = 0; i < 63; i++) ocioso("to_espera", ex(0, 0, 0, 2, 0));
    ocioso("to_expira", ex(1, 0, 0, 0, 1));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vetores, n_erros);
    $finish;
  end

endmodule
